// File: rtl/enc6b8b_pkg.sv
// Shared constants and state type for the 6b->8b transmit encoder.
package enc6b8b_pkg;

  localparam logic [5:0] K_SYNC = 6'b000111;
  localparam logic [5:0] K_IDLE = 6'b010101;
  localparam logic [5:0] K_ALT0 = 6'b111000;
  localparam logic [5:0] K_ALT1 = 6'b101010;

  localparam logic [7:0] SYM_SYNC = 8'b01000111;
  localparam logic [7:0] SYM_IDLE = 8'b01010101;
  localparam logic [7:0] SYM_ALT0 = 8'b01111000;
  localparam logic [7:0] SYM_ALT1 = 8'b01101010;

  // Prefixes that lift a 6-bit word of popcount 2/3/4 to exactly four 1s
  localparam logic [1:0] PFX_POP2 = 2'b11;
  localparam logic [1:0] PFX_POP3 = 2'b10;
  localparam logic [1:0] PFX_POP4 = 2'b00;

  typedef enum logic {ALIGN, RUN} linkState_e;

endpackage

// File: rtl/encoder6b_to_8b_map.sv
// Combinational {isK, data} -> 8-bit balanced code, flagging unsupported K words.
module encoder6b_to_8b_map
  import enc6b8b_pkg::*;
(
  input  logic       isK,
  input  logic [5:0] data,
  output logic [7:0] code,
  output logic       kIllegal
);

  logic [2:0] ones;

  always_comb begin
    code     = SYM_IDLE;
    kIllegal = 1'b0;
    ones     = 3'($countones(data));
    if (isK) begin
      case (data)
        K_SYNC:  code = SYM_SYNC;
        K_IDLE:  code = SYM_IDLE;
        K_ALT0:  code = SYM_ALT0;
        K_ALT1:  code = SYM_ALT1;
        default: kIllegal = 1'b1;
      endcase
    end else begin
      // Explicit entries cover every word whose popcount prefix cannot balance it
      case (data)
        6'b000000: code = 8'b01011001;
        6'b111111: code = 8'b01100110;
        6'b111110: code = 8'b01001110;
        6'b111101: code = 8'b01001101;
        6'b111011: code = 8'b01011010;
        6'b110111: code = 8'b01010110;
        6'b101111: code = 8'b01101100;
        6'b011111: code = 8'b01011100;
        6'b000001: code = 8'b01110001;
        6'b000010: code = 8'b01110010;
        6'b000100: code = 8'b01100101;
        6'b001000: code = 8'b01101001;
        6'b010000: code = 8'b01010011;
        6'b100000: code = 8'b01100011;
        6'b001111: code = 8'b01001011;
        6'b110000: code = 8'b01110100;
        default: begin
          case (ones)
            3'd3:    code = {PFX_POP3, data};
            3'd4:    code = {PFX_POP4, data};
            default: code = {PFX_POP2, data};
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/encoder6b_to_8b_tx.sv
// Transmit-side 6b->8b encoder: alignment burst, periodic SYNC, IDLE fill, one symbol per symEn.
module encoder6b_to_8b_tx
  import enc6b8b_pkg::*;
#(
  parameter int unsigned SYNC_LEN    = 32,
  parameter int unsigned SYNC_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       symEn,
  input  logic       realign,
  input  logic [5:0] inData,
  input  logic       inIsK,
  input  logic       inValid,
  output logic       inReady,
  output logic [7:0] encodedData,
  output logic       encodedValid,
  output logic       linkUp,
  output logic       kError
);

  localparam int unsigned AlignW   = $clog2(SYNC_LEN + 1);
  localparam int unsigned PeriodW  = (SYNC_PERIOD > 0) ? $clog2(SYNC_PERIOD + 1) : 1;
  localparam bit          PeriodOn = (SYNC_PERIOD != 0);
  localparam logic [AlignW-1:0]  AlignLast  = AlignW'(SYNC_LEN - 1);
  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(SYNC_PERIOD - 1);

  linkState_e         stateQ, stateD;
  logic [AlignW-1:0]  alignCntQ, alignCntD;
  logic [PeriodW-1:0] periodCntQ, periodCntD;
  logic [7:0]         dataQ, dataD;
  logic               validQ;
  logic               kErrQ, kErrD;
  logic               syncDue, transfer;
  logic [7:0]         mapCode;
  logic               mapIllegal;

  encoder6b_to_8b_map uMap (
    .isK      (inIsK),
    .data     (inData),
    .code     (mapCode),
    .kIllegal (mapIllegal)
  );

  assign linkUp   = (stateQ == RUN);
  assign syncDue  = linkUp && PeriodOn && (periodCntQ == PeriodLast);
  assign inReady  = symEn & linkUp & ~syncDue & ~realign;
  assign transfer = inReady & inValid;

  always_comb begin
    stateD     = stateQ;
    alignCntD  = alignCntQ;
    periodCntD = periodCntQ;
    dataD      = dataQ;
    kErrD      = kErrQ;
    if (realign) begin
      // Realign overrides everything; the burst count restarts after this cycle
      stateD    = ALIGN;
      alignCntD = '0;
      if (symEn) dataD = SYM_SYNC;
    end else if (symEn) begin
      unique case (stateQ)
        ALIGN: begin
          dataD = SYM_SYNC;
          if (alignCntQ == AlignLast) begin
            stateD     = RUN;
            alignCntD  = '0;
            periodCntD = '0;
          end else begin
            alignCntD = alignCntQ + 1'b1;
          end
        end
        RUN: begin
          if (syncDue) begin
            dataD      = SYM_SYNC;
            periodCntD = '0;
          end else begin
            dataD      = transfer ? mapCode : SYM_IDLE;
            periodCntD = periodCntQ + 1'b1;
            if (transfer && mapIllegal) kErrD = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= ALIGN;
      alignCntQ  <= '0;
      periodCntQ <= '0;
      dataQ      <= SYM_IDLE;
      validQ     <= 1'b0;
      kErrQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      alignCntQ  <= alignCntD;
      periodCntQ <= periodCntD;
      dataQ      <= dataD;
      validQ     <= symEn;
      kErrQ      <= kErrD;
    end
  end

  assign encodedData  = dataQ;
  assign encodedValid = validQ;
  assign kError       = kErrQ;

endmodule

// File: tb/tb_encoder6b_to_8b_tx.sv
// Self-checking bench for encoder6b_to_8b_tx against a behavioural link model.
module tb_encoder6b_to_8b_tx;

  localparam int unsigned SyncLen    = 4;
  localparam int unsigned SyncPeriod = 8;
  localparam logic [7:0]  SymSync    = 8'b01000111;
  localparam logic [7:0]  SymIdle    = 8'b01010101;

  logic       clk = 1'b0;
  logic       rst_n, symEn, realign, inValid, inIsK, inReady;
  logic [5:0] inData;
  logic [7:0] encodedData;
  logic       encodedValid, linkUp, kError;

  always #5 clk = ~clk;

  encoder6b_to_8b_tx #(
    .SYNC_LEN    (SyncLen),
    .SYNC_PERIOD (SyncPeriod)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .symEn        (symEn),
    .realign      (realign),
    .inData       (inData),
    .inIsK        (inIsK),
    .inValid      (inValid),
    .inReady      (inReady),
    .encodedData  (encodedData),
    .encodedValid (encodedValid),
    .linkUp       (linkUp),
    .kError       (kError)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the link
  bit         mRun;
  int         mAlign, mPeriod;
  logic [7:0] mData;
  bit         mValid, mKerr;

  logic [5:0] excIn [16] = '{6'b000000, 6'b111111, 6'b111110, 6'b111101, 6'b111011, 6'b110111,
                             6'b101111, 6'b011111, 6'b000001, 6'b000010, 6'b000100, 6'b001000,
                             6'b010000, 6'b100000, 6'b001111, 6'b110000};
  logic [7:0] excOut [16] = '{8'b01011001, 8'b01100110, 8'b01001110, 8'b01001101, 8'b01011010,
                              8'b01010110, 8'b01101100, 8'b01011100, 8'b01110001, 8'b01110010,
                              8'b01100101, 8'b01101001, 8'b01010011, 8'b01100011, 8'b01001011,
                              8'b01110100};
  logic [5:0] legalK [4] = '{6'b000111, 6'b010101, 6'b111000, 6'b101010};

  function automatic void refEncode(input bit isK, input logic [5:0] d,
                                    output logic [7:0] code, output bit illegal);
    illegal = 1'b0;
    code    = SymIdle;
    if (isK) begin
      if (d == 6'b000111)      code = SymSync;
      else if (d == 6'b010101) code = SymIdle;
      else if (d == 6'b111000) code = 8'b01111000;
      else if (d == 6'b101010) code = 8'b01101010;
      else                     illegal = 1'b1;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (excIn[i] == d) begin
        code = excOut[i];
        return;
      end
    end
    case ($countones(d))
      2:       code = {2'b11, d};
      3:       code = {2'b10, d};
      4:       code = {2'b00, d};
      default: code = 8'hxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mRun = 0; mAlign = 0; mPeriod = 0; mData = SymIdle; mValid = 0; mKerr = 0;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check, advance the model.
  task automatic step(input bit se, input bit ra, input bit iv, input bit ik,
                      input logic [5:0] id, output bit acc);
    bit         due, expRdy, ill;
    logic [7:0] code;
    symEn = se; realign = ra; inValid = iv; inIsK = ik; inData = id;
    due    = mRun && (SyncPeriod != 0) && (mPeriod == SyncPeriod - 1);
    expRdy = se && mRun && !due && !ra;
    @(negedge clk);
    check("inReady", inReady, expRdy);
    refEncode(ik, id, code, ill);
    mValid = se;
    if (ra) begin
      if (se) mData = SymSync;
      mRun = 0; mAlign = 0;
    end else if (se) begin
      if (!mRun) begin
        mData = SymSync;
        mAlign++;
        if (mAlign == SyncLen) begin mRun = 1; mAlign = 0; mPeriod = 0; end
      end else if (due) begin
        mData = SymSync; mPeriod = 0;
      end else begin
        if (iv) begin
          mData = code;
          if (ill) mKerr = 1;
        end else begin
          mData = SymIdle;
        end
        mPeriod++;
      end
    end
    @(posedge clk);
    #1;
    check("encodedData", encodedData, mData);
    check("encodedValid", encodedValid, mValid);
    check("linkUp", linkUp, mRun);
    check("kError", kError, mKerr);
    if (se) check("popcount", $countones(encodedData), 4);
    acc = expRdy && iv;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".encodedData"}, encodedData, SymIdle);
    check({tag, ".encodedValid"}, encodedValid, 1'b0);
    check({tag, ".linkUp"}, linkUp, 1'b0);
    check({tag, ".kError"}, kError, 1'b0);
    check({tag, ".inReady"}, inReady, 1'b0);
  endtask

  task automatic sendWord(input bit ik, input logic [5:0] id, input string tag);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(1, 0, 1, ik, id, acc);
      tries++;
    end while (!acc && tries < 2 * SyncPeriod);
    if (!acc) begin
      errors++;
      $error("FAIL %s: word %0h not accepted within %0d strobes", tag, id, tries);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         acc, ik;
    logic [5:0] d;
    rst_n = 1'b0; symEn = 0; realign = 0; inValid = 0; inIsK = 0; inData = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Alignment burst: SYNC_LEN SYNC symbols, then linkUp
    for (int i = 0; i < SyncLen; i++) step(1, 0, 0, 0, '0, acc);
    check("linkUpAfterBurst", linkUp, 1'b1);

    // Every data word through the map
    for (int w = 0; w < 64; w++) sendWord(0, 6'(w), "dataWord");

    // inValid held high across several SYNC periods
    for (int i = 0; i < 3 * SyncPeriod; i++) step(1, 0, 1, 0, 6'($urandom), acc);

    // Idle fill with a sparse strobe: output must hold between strobes
    for (int r = 0; r < 3; r++) begin
      step(1, 0, 0, 0, '0, acc);
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 6'($urandom), acc);
    end

    // Illegal K word: consumed, IDLE sent, sticky error
    sendWord(1, 6'b110011, "illegalK");
    check("kErrorSet", kError, 1'b1);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 6'($urandom), acc);
    check("kErrorSticky", kError, 1'b1);

    // Realign during a pending transfer
    step(1, 1, 1, 0, 6'($urandom), acc);
    check("realignLinkDown", linkUp, 1'b0);
    for (int i = 0; i < SyncLen; i++) step(1, 0, 1, 0, 6'($urandom), acc);
    check("realignRelink", linkUp, 1'b1);

    // Realign while already aligning restarts the burst
    step(1, 1, 0, 0, '0, acc);
    step(1, 0, 0, 0, '0, acc);
    step(1, 1, 0, 0, '0, acc);
    for (int i = 0; i < SyncLen; i++) step(1, 0, 0, 0, '0, acc);

    // Randomized soak
    for (int i = 0; i < 600; i++) begin
      ik = ($urandom_range(7) == 0);
      d  = (ik && $urandom_range(1) == 1) ? legalK[$urandom_range(3)] : 6'($urandom);
      step(($urandom_range(9) < 7), ($urandom_range(49) == 0), ($urandom_range(3) != 0), ik,
           d, acc);
    end

    // Asynchronous reset in mid-cycle
    symEn = 1; inValid = 1; inIsK = 0; inData = 6'b101010; realign = 0;
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkResetOutputs("asyncReset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < SyncLen; i++) step(1, 0, 1, 0, 6'($urandom), acc);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 6'($urandom), acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
